axi_dw_allocator_len: RTL and testbench
=======================================

# axi_dw_allocator_len

Write-data (W channel) allocator for the AXI node slave side: forwards W beats from N_TARG_PORT target ports to one slave port in the order their AW requests were granted. It is the parametrised successor of the ID-ordered W allocator:

- Each queued entry also carries the burst length (AWLEN), so the allocator counts beats itself.
- It regenerates wlast_o from that count and flags masters whose wlast disagrees.
- A compile-time output register slice is optional.

## Interface
- AXI_DATA_W, 64, data width in bits; AXI_NUMBYTES = AXI_DATA_W/8 (derived).
- AXI_USER_W, 6, W user sideband width.
- N_TARG_PORT, 7, number of target ports (>=2).
- LOG_N_TARG, $clog2(N_TARG_PORT), width of the binary port index.
- FIFO_DEPTH, 8, order-FIFO entries; power of two, >=2.
- AXI_LEN_W, 8, burst-length field width.
- clk  in  1  clock; everything is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wdata_i / wstrb_i / wlast_i / wuser_i  in  N_TARG_PORT x (AXI_DATA_W / AXI_NUMBYTES / 1 / AXI_USER_W)  per-port W payload.
- wvalid_i  in  N_TARG_PORT  per-port beat valid.
- wready_o  out  N_TARG_PORT  per-port beat ready; at most one bit set.
- wdata_o / wstrb_o / wlast_o / wuser_o  out  AXI_DATA_W / AXI_NUMBYTES / 1 / AXI_USER_W  slave-side payload.
- wvalid_o  out  1  slave-side valid.
- wready_i  in  1  slave-side ready.
- push_id_i  in  1  push request, from the AW arbiter.
- id_bin_i  in  LOG_N_TARG  binary index of the granted port.
- len_i  in  AXI_LEN_W  AWLEN of the granted burst (beats-1).
- grant_id_o  out  1  FIFO can accept a push.
- fifo_level_o  out  $clog2(FIFO_DEPTH+1)  number of queued entries.
- err_last_o  out  1  one-cycle pulse: a master's wlast mismatched the expected position.
- err_port_o  out  LOG_N_TARG  port index of the last error; held until the next error.

## Operation
- **Order FIFO:** internal circular FIFO of {id_bin, len}; it is not a fall-through FIFO.
  - grant_id_o = !full.
  - A push happens when push_id_i && grant_id_o.
  - A pop happens on the accepted final beat of the head burst.
  - id_bin_i >= N_TARG_PORT is a protocol violation; behaviour is undefined.
- **Beat counter** beat_cnt (AXI_LEN_W bits): cleared on reset and on each pop; incremented on every accepted non-final beat.
  - Accepted beat = wvalid_o && wready_i at the slave side of the mux.
  - Final beat = beat_cnt == head.len.
- **FSM, two states:**
  - IDLE: FIFO empty. wvalid_o=0, wready_o=0, payload outputs=0. Goes to ACTIVE when the level becomes non-zero.
  - ACTIVE: head entry selects port p = head.id_bin.
    - wvalid_o = wvalid_i[p]; wready_o = onehot(p) & {wready_i}; payload = port p.
    - wlast_o = (beat_cnt == head.len); wlast_i[p] is not forwarded.
    - After an accepted final beat: stays ACTIVE if another entry remains, otherwise returns to IDLE.
- **Error check:** on every accepted beat, if wlast_i[p] != expected last, err_last_o pulses the next cycle and err_port_o <= p. Forwarding continues using the counter.
- **Simultaneous push and pop:** the level is unchanged and both take effect. A push while full is refused (grant_id_o=0), even if a pop happens in the same cycle.

## Timing
- **Reset values:** wvalid_o=0, wready_o=0, payload outputs=0, grant_id_o=1, fifo_level_o=0, err_last_o=0, err_port_o=0, FSM=IDLE, beat_cnt=0.
- **FIFO latency:** a push in cycle t makes the entry the head in cycle t+1 if the FIFO was empty. The first beat can therefore be forwarded in t+1 at the earliest.
- **Datapath latency:** without the register slice, wvalid_i→wvalid_o, wready_i→wready_o and payload are combinational (0 cycles).
- **Back-to-back bursts:** consecutive bursts (different or same port) have no bubble. The head advances in the same cycle as the final beat is accepted.
- **Reset mid-burst:** the FIFO is flushed, outputs go to reset values immediately, and partially transferred bursts are discarded.

## Configuration
- **AXI_DW_OUT_REG_EN defined:** a 2-entry skid buffer is placed on the slave side.
  - wvalid_o and payload are driven from registers; wready_o depends only on skid occupancy, not on wready_i.
  - Latency +1 cycle; full throughput is kept.
  - Skid registers reset to 0.
- **Not defined:** combinational path as described in Operation.

## Test plan
- **Single beat:** push {id=2,len=0}; wvalid_i[2]=1, wlast_i[2]=1, wready_i=1 -> one beat out with wlast_o=1, wready_o=0b0000100, and fifo_level_o returns 1->0.
- **Ordered bursts:** push id=3 len=3, then id=0 len=1; ports 0 and 3 always valid -> 4 beats from port 3 (wlast_o on the 4th), then 2 from port 0, with no idle cycle between them.
- **Full FIFO:** 8 pushes with wready_i=0 -> grant_id_o=0 and fifo_level_o=8, and a 9th push is ignored. One pop plus a simultaneous push attempt -> the push is refused and the level becomes 7.
- **Wlast mismatch:** len=3, master asserts wlast_i on beat 2 -> err_last_o pulses 1 cycle later, err_port_o = port index, the burst still ends on beat 4, and the FIFO pops once.
- **Backpressure:** wready_i toggles 1/0 during a len=7 burst -> exactly 8 accepted beats, and payload stays stable while stalled.
- **Reset mid-burst:** assert rst_n=0 after 2 beats of len=5 -> all outputs go to reset values immediately and the FIFO is empty afterwards. Repeat the whole suite with AXI_DW_OUT_REG_EN defined, expecting +1 cycle latency.

Source files
------------

// File: rtl/axi_dw_allocator_len.sv
// axi_dw_allocator_len
// W-channel allocator for the AXI node slave side. Every AW grant pushes
// {port index, AWLEN} into an order FIFO; W beats are then forwarded from
// the head entry's port, in grant order. The allocator counts beats itself,
// regenerates wlast_o from that count and flags masters whose wlast_i
// disagrees with it.
//
// Optional feature macro: AXI_DW_OUT_REG_EN
//   defined   -> 2-entry skid buffer on the slave side (+1 cycle latency)
//   undefined -> slave side is a combinational mux of the head port
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   w*_i[N_TARG_PORT]     per-port W payload / valid
//   wready_o              per-port ready, at most one bit set
//   w*_o, wvalid_o        slave-side W payload / valid
//   wready_i              slave-side ready
//   push_id_i, id_bin_i,  AW grant: push request, granted port, AWLEN
//   len_i
//   grant_id_o            order FIFO can accept a push
//   fifo_level_o          queued entries
//   err_last_o            1-cycle pulse: a master's wlast_i was wrong
//   err_port_o            port of the most recent wlast error (held)
//   dbg_state_o           FSM state (0 = IDLE, 1 = ACTIVE)
//
// Handshake: a beat moves across an interface on a rising edge where
// valid and ready are both high. Valid never waits on ready; the payload
// is only meaningful while valid is high.
module axi_dw_allocator_len #(
    parameter int AXI_DATA_W   = 64,
    parameter int AXI_NUMBYTES = AXI_DATA_W / 8,
    parameter int AXI_USER_W   = 6,
    parameter int N_TARG_PORT  = 7,
    parameter int LOG_N_TARG   = $clog2(N_TARG_PORT),
    parameter int FIFO_DEPTH   = 8,
    parameter int AXI_LEN_W    = 8,
    parameter int LEVEL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AXI_DATA_W-1:0]   wdata_i [N_TARG_PORT],
    input  logic [AXI_NUMBYTES-1:0] wstrb_i [N_TARG_PORT],
    input  logic [N_TARG_PORT-1:0]  wlast_i,
    input  logic [AXI_USER_W-1:0]   wuser_i [N_TARG_PORT],
    input  logic [N_TARG_PORT-1:0]  wvalid_i,
    output logic [N_TARG_PORT-1:0]  wready_o,
    output logic [AXI_DATA_W-1:0]   wdata_o,
    output logic [AXI_NUMBYTES-1:0] wstrb_o,
    output logic                    wlast_o,
    output logic [AXI_USER_W-1:0]   wuser_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic                    push_id_i,
    input  logic [LOG_N_TARG-1:0]   id_bin_i,
    input  logic [AXI_LEN_W-1:0]    len_i,
    output logic                    grant_id_o,
    output logic [LEVEL_W-1:0]      fifo_level_o,
    output logic                    err_last_o,
    output logic [LOG_N_TARG-1:0]   err_port_o,
    output logic                    dbg_state_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PAY_W = AXI_DATA_W + AXI_NUMBYTES + AXI_USER_W + 1;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                  state;
    logic [LOG_N_TARG-1:0]   fifo_id  [FIFO_DEPTH];
    logic [AXI_LEN_W-1:0]    fifo_len [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [LEVEL_W-1:0]      level, level_nxt;
    logic [AXI_LEN_W-1:0]    beat_cnt;

    logic                    full, push, pop, active;
    logic [LOG_N_TARG-1:0]   head_id;
    logic [AXI_LEN_W-1:0]    head_len;
    logic                    exp_last;
    logic                    mux_valid, sink_ready, beat_acc, last_err;
    logic [PAY_W-1:0]        mux_pay;

    assign full       = (level == LEVEL_W'(FIFO_DEPTH));
    // A push is refused while full even if the head pops in the same cycle.
    assign push       = push_id_i && !full;
    assign head_id    = fifo_id[rd_ptr];
    assign head_len   = fifo_len[rd_ptr];
    assign active     = (state == ACTIVE);
    assign exp_last   = (beat_cnt == head_len);
    assign mux_valid  = active && wvalid_i[head_id];
    assign beat_acc   = mux_valid && sink_ready;
    assign pop        = beat_acc && exp_last;
    assign last_err   = beat_acc && (wlast_i[head_id] != exp_last);
    assign level_nxt  = level + LEVEL_W'(push) - LEVEL_W'(pop);

    assign grant_id_o   = !full;
    assign fifo_level_o = level;
    assign dbg_state_o  = active;

    // Head port payload; wlast comes from the beat counter, not the master.
    always_comb begin
        mux_pay = '0;
        if (active) begin
            mux_pay = {wdata_i[head_id], wstrb_i[head_id], wuser_i[head_id], exp_last};
        end
    end

    always_comb begin
        wready_o = '0;
        if (active) begin
            wready_o[head_id] = sink_ready;
        end
    end

    // Order FIFO storage: contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]  <= id_bin_i;
            fifo_len[wr_ptr] <= len_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            beat_cnt   <= '0;
            err_last_o <= 1'b0;
            err_port_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_nxt;

            if (pop)           beat_cnt <= '0;
            else if (beat_acc) beat_cnt <= beat_cnt + AXI_LEN_W'(1);

            err_last_o <= last_err;
            if (last_err) err_port_o <= head_id;

            // Head advances on the final beat, so the next burst needs no bubble.
            case (state)
                IDLE:    if (level_nxt != '0) state <= ACTIVE;
                ACTIVE:  if (level_nxt == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_DW_OUT_REG_EN
    // Output register plus one skid entry. The skid only fills when the
    // output register is stalled, so upstream ready depends on skid
    // occupancy alone and throughput stays at one beat per cycle.
    logic             out_valid, skid_valid;
    logic [PAY_W-1:0] out_pay, skid_pay;

    assign sink_ready = !skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_pay    <= '0;
            skid_pay   <= '0;
        end else if (!out_valid || wready_i) begin
            if (skid_valid) begin
                out_pay    <= skid_pay;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= beat_acc;
                if (beat_acc) out_pay <= mux_pay;
            end
        end else if (beat_acc) begin
            skid_pay   <= mux_pay;
            skid_valid <= 1'b1;
        end
    end

    assign wvalid_o = out_valid;
    assign {wdata_o, wstrb_o, wuser_o, wlast_o} = out_pay;
`else
    assign sink_ready = wready_i;
    assign wvalid_o   = mux_valid;
    assign {wdata_o, wstrb_o, wuser_o, wlast_o} = mux_pay;
`endif

endmodule

// File: tb/tb_axi_dw_allocator_len.sv
// Bench for axi_dw_allocator_len. Masters hold per-port beat queues; every
// granted burst also appends its expected output beats (with the position-
// derived wlast) to exp_q, and beats seen on the slave side go to obs_q.
module tb_axi_dw_allocator_len;
    localparam int N    = 7;
    localparam int DW   = 64;
    localparam int NB   = 8;
    localparam int UW   = 6;
    localparam int LOGN = 3;
    localparam int LW   = 8;
    localparam int LVW  = 4;
    localparam int BW   = DW + NB + UW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]   wdata_i [N];
    logic [NB-1:0]   wstrb_i [N];
    logic [N-1:0]    wlast_i;
    logic [UW-1:0]   wuser_i [N];
    logic [N-1:0]    wvalid_i;
    logic [N-1:0]    wready_o;
    logic [DW-1:0]   wdata_o;
    logic [NB-1:0]   wstrb_o;
    logic            wlast_o;
    logic [UW-1:0]   wuser_o;
    logic            wvalid_o;
    logic            wready_i;
    logic            push_id_i;
    logic [LOGN-1:0] id_bin_i;
    logic [LW-1:0]   len_i;
    logic            grant_id_o;
    logic [LVW-1:0]  fifo_level_o;
    logic            err_last_o;
    logic [LOGN-1:0] err_port_o;
    logic            dbg_state_o;

    axi_dw_allocator_len dut (
        .clk(clk), .rst_n(rst_n),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wuser_i(wuser_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wuser_o(wuser_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .push_id_i(push_id_i), .id_bin_i(id_bin_i), .len_i(len_i),
        .grant_id_o(grant_id_o), .fifo_level_o(fifo_level_o),
        .err_last_o(err_last_o), .err_port_o(err_port_o), .dbg_state_o(dbg_state_o)
    );

    int checks = 0;
    int failures = 0;

    logic [BW-1:0] port_q [N][$];
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] obs_q[$];
    int            acc_cyc_q[$];
    int            take_cyc_q[$];
    int            valid_pct = 100;
    int            rdy_mode = 1;   // 0 low, 1 high, 2 toggle, 3 random
    logic          push_acc = 1'b0;
    int            err_seen = 0;
    logic [LOGN-1:0] err_port_seen = '0;
    int            err_cyc = 0;
    int            cyc = 0;
    int            stall_viol = 0;
    int            multi_rdy = 0;
    logic          stalled_prev = 1'b0;
    logic [BW-1:0] stalled_pay = '0;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_ports(input logic [N-1:0] took);
        for (int i = 0; i < N; i++) begin
            if (wvalid_i[i] && !took[i]) begin
                // hold the beat until it is taken
            end else if (port_q[i].size() > 0 && $urandom_range(99) < valid_pct) begin
                wvalid_i[i] = 1'b1;
                {wdata_i[i], wstrb_i[i], wuser_i[i], wlast_i[i]} = port_q[i][0];
            end else begin
                wvalid_i[i] = 1'b0;
                wdata_i[i]  = {$urandom, $urandom};
                wlast_i[i]  = 1'($urandom);
            end
        end
        case (rdy_mode)
            0:       wready_i = 1'b0;
            1:       wready_i = 1'b1;
            2:       wready_i = ~wready_i;
            default: wready_i = 1'($urandom);
        endcase
    endtask

    // One clock: sample at the negedge, record, then drive after the posedge.
    task automatic tick();
        logic [N-1:0]  took;
        logic          acc;
        logic [BW-1:0] pay;
        @(negedge clk);
        cyc++;
        pay  = {wdata_o, wstrb_o, wuser_o, wlast_o};
        acc  = wvalid_o && wready_i;
        took = wvalid_i & wready_o;
        if ($countones(wready_o) > 1) multi_rdy++;
        if (stalled_prev && (!wvalid_o || pay != stalled_pay)) stall_viol++;
        stalled_prev = wvalid_o && !wready_i;
        stalled_pay  = pay;
        if (err_last_o) begin
            err_seen++;
            err_port_seen = err_port_o;
            err_cyc = cyc;
        end
        push_acc = push_id_i && grant_id_o;
        @(posedge clk);
        #1;
        if (acc) begin
            obs_q.push_back(pay);
            acc_cyc_q.push_back(cyc);
        end
        for (int i = 0; i < N; i++) begin
            if (took[i]) begin
                void'(port_q[i].pop_front());
                take_cyc_q.push_back(cyc);
            end
        end
        push_id_i = 1'b0;
        drive_ports(took);
    endtask

    // Request a grant; if accepted, the master queue and the expected stream
    // grow by len+1 beats. bad=1 makes the master also raise wlast on beat 2.
    task automatic push_burst(input int id, input int len, input bit bad);
        logic [DW-1:0] d;
        logic [NB-1:0] s;
        logic [UW-1:0] u;
        push_id_i = 1'b1;
        id_bin_i  = LOGN'(id);
        len_i     = LW'(len);
        tick();
        if (push_acc) begin
            for (int k = 0; k <= len; k++) begin
                d = {$urandom, $urandom};
                s = NB'($urandom);
                u = UW'($urandom);
                port_q[id].push_back({d, s, u, (k == len) || (bad && k == 1)});
                exp_q.push_back({d, s, u, (k == len)});
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        acc_cyc_q.delete();
        take_cyc_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        wready_i = 1'b0; push_id_i = 1'b0; id_bin_i = '0; len_i = '0;
        wvalid_i = '0; wlast_i = '0;
        for (int i = 0; i < N; i++) begin
            wdata_i[i] = '0; wstrb_i[i] = '0; wuser_i[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wvalid_o !== 1'b0) begin failures++; $display("FAIL reset_wvalid: got %0b expected 0", wvalid_o); end
        checks++; if (wready_o !== '0) begin failures++; $display("FAIL reset_wready: got %b expected 0", wready_o); end
        checks++; if ({wdata_o, wstrb_o, wuser_o, wlast_o} !== '0) begin failures++; $display("FAIL reset_payload: got %0h expected 0", {wdata_o, wstrb_o, wuser_o, wlast_o}); end
        checks++; if (grant_id_o !== 1'b1) begin failures++; $display("FAIL reset_grant: got %0b expected 1", grant_id_o); end
        checks++; if (fifo_level_o !== '0) begin failures++; $display("FAIL reset_level: got %0d expected 0", fifo_level_o); end
        checks++; if (err_last_o !== 1'b0 || err_port_o !== '0) begin failures++; $display("FAIL reset_err: got %0b/%0d expected 0/0", err_last_o, err_port_o); end
        checks++; if (dbg_state_o !== 1'b0) begin failures++; $display("FAIL reset_state: got %0b expected 0", dbg_state_o); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wready_i = 1'b1;
    endtask

    task automatic test_single_beat();
        logic [DW-1:0] d;
        d = {$urandom, $urandom};
        wvalid_i[2] = 1'b1; wlast_i[2] = 1'b1; wdata_i[2] = d;
        wready_i = 1'b1;
        push_id_i = 1'b1; id_bin_i = 3'd2; len_i = '0;
        @(negedge clk);
        checks++; if (fifo_level_o !== 4'd0 || wvalid_o !== 1'b0) begin failures++; $display("FAIL single_push_cycle: got level %0d valid %0b expected 0 0", fifo_level_o, wvalid_o); end
        @(posedge clk); #1;
        push_id_i = 1'b0;
        @(negedge clk);
        checks++; if (fifo_level_o !== 4'd1) begin failures++; $display("FAIL single_level1: got %0d expected 1", fifo_level_o); end
        checks++; if (wready_o !== 7'b0000100) begin failures++; $display("FAIL single_wready: got %b expected 0000100", wready_o); end
        checks++; if (dbg_state_o !== 1'b1) begin failures++; $display("FAIL single_state: got %0b expected 1", dbg_state_o); end
`ifdef AXI_DW_OUT_REG_EN
        checks++; if (wvalid_o !== 1'b0) begin failures++; $display("FAIL single_regdelay: got %0b expected 0", wvalid_o); end
`else
        checks++; if (wvalid_o !== 1'b1 || wlast_o !== 1'b1 || wdata_o !== d) begin failures++; $display("FAIL single_beat: got v%0b l%0b %0h expected v1 l1 %0h", wvalid_o, wlast_o, wdata_o, d); end
`endif
        @(posedge clk); #1;
        wvalid_i[2] = 1'b0; wlast_i[2] = 1'b0;
        @(negedge clk);
        checks++; if (fifo_level_o !== 4'd0) begin failures++; $display("FAIL single_level0: got %0d expected 0", fifo_level_o); end
`ifdef AXI_DW_OUT_REG_EN
        checks++; if (wvalid_o !== 1'b1 || wlast_o !== 1'b1 || wdata_o !== d) begin failures++; $display("FAIL single_beat: got v%0b l%0b %0h expected v1 l1 %0h", wvalid_o, wlast_o, wdata_o, d); end
        @(posedge clk); #1;
        @(negedge clk);
`endif
        checks++; if (wvalid_o !== 1'b0) begin failures++; $display("FAIL single_after: got %0b expected 0", wvalid_o); end
        @(posedge clk); #1;
        stalled_prev = 1'b0;
    endtask

    task automatic test_ordered_bursts();
        valid_pct = 100; rdy_mode = 1; clear_sb();
        push_burst(3, 3, 0);
        push_burst(0, 1, 0);
        drain(100);
        checks++; if (obs_q.size() !== 6) begin failures++; $display("FAIL ordered_count: got %0d expected 6", obs_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== exp_q[k]) begin failures++; $display("FAIL ordered_beat%0d: got %0h expected %0h", k, obs_q[k], exp_q[k]); end
        end
        if (acc_cyc_q.size() == 6) begin
            checks++; if (acc_cyc_q[5] - acc_cyc_q[0] !== 5) begin failures++; $display("FAIL ordered_nobubble: got span %0d expected 5", acc_cyc_q[5] - acc_cyc_q[0]); end
        end
        checks++; if (fifo_level_o !== 4'd0) begin failures++; $display("FAIL ordered_level: got %0d expected 0", fifo_level_o); end
        clear_sb();
    endtask

    task automatic test_full_fifo();
        valid_pct = 0; rdy_mode = 0; clear_sb();
        for (int i = 0; i < 8; i++) push_burst(1, 0, 0);
        #2;
        checks++; if (grant_id_o !== 1'b0) begin failures++; $display("FAIL full_grant: got %0b expected 0", grant_id_o); end
        checks++; if (fifo_level_o !== 4'd8) begin failures++; $display("FAIL full_level: got %0d expected 8", fifo_level_o); end
        push_burst(1, 0, 0);
        checks++; if (push_acc !== 1'b0) begin failures++; $display("FAIL full_ninth_push: got %0b expected 0", push_acc); end
        #2;
        checks++; if (fifo_level_o !== 4'd8) begin failures++; $display("FAIL full_level_after9: got %0d expected 8", fifo_level_o); end
        valid_pct = 100; rdy_mode = 1;
        tick();
        push_id_i = 1'b1; id_bin_i = 3'd2; len_i = '0;
        tick();
        checks++; if (push_acc !== 1'b0) begin failures++; $display("FAIL full_push_on_pop: got %0b expected 0", push_acc); end
        #2;
        checks++; if (fifo_level_o !== 4'd7) begin failures++; $display("FAIL full_level7: got %0d expected 7", fifo_level_o); end
        drain(200);
        checks++; if (obs_q.size() !== 8) begin failures++; $display("FAIL full_count: got %0d expected 8", obs_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== exp_q[k]) begin failures++; $display("FAIL full_beat%0d: got %0h expected %0h", k, obs_q[k], exp_q[k]); end
        end
        clear_sb();
    endtask

    task automatic test_wlast_mismatch();
        valid_pct = 100; rdy_mode = 1; clear_sb();
        err_seen = 0;
        push_burst(4, 3, 1);
        drain(100);
        tick(); tick();
        checks++; if (err_seen !== 1) begin failures++; $display("FAIL mismatch_pulses: got %0d expected 1", err_seen); end
        checks++; if (err_port_seen !== 3'd4) begin failures++; $display("FAIL mismatch_port: got %0d expected 4", err_port_seen); end
        checks++; if (take_cyc_q.size() !== 4) begin failures++; $display("FAIL mismatch_takes: got %0d expected 4", take_cyc_q.size()); end
        if (take_cyc_q.size() >= 2) begin
            checks++; if (err_cyc !== take_cyc_q[1] + 1) begin failures++; $display("FAIL mismatch_timing: got cycle %0d expected %0d", err_cyc, take_cyc_q[1] + 1); end
        end
        checks++; if (obs_q.size() !== 4) begin failures++; $display("FAIL mismatch_count: got %0d expected 4", obs_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== exp_q[k]) begin failures++; $display("FAIL mismatch_beat%0d: got %0h expected %0h", k, obs_q[k], exp_q[k]); end
        end
        checks++; if (fifo_level_o !== 4'd0) begin failures++; $display("FAIL mismatch_level: got %0d expected 0", fifo_level_o); end
        clear_sb();
    endtask

    task automatic test_backpressure();
        valid_pct = 100; rdy_mode = 2; clear_sb();
        err_seen = 0; stall_viol = 0;
        push_burst(5, 7, 0);
        drain(200);
        tick(); tick();
        checks++; if (obs_q.size() !== 8) begin failures++; $display("FAIL bp_count: got %0d expected 8", obs_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== exp_q[k]) begin failures++; $display("FAIL bp_beat%0d: got %0h expected %0h", k, obs_q[k], exp_q[k]); end
        end
        checks++; if (stall_viol !== 0) begin failures++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_viol); end
        checks++; if (err_seen !== 0 || err_port_o !== 3'd4) begin failures++; $display("FAIL bp_err_hold: got %0d/%0d expected 0/4", err_seen, err_port_o); end
        clear_sb();
    endtask

    task automatic test_random();
        valid_pct = 70; rdy_mode = 3; clear_sb();
        err_seen = 0; multi_rdy = 0; stall_viol = 0;
        for (int b = 0; b < 24; b++) begin
            push_burst(int'($urandom_range(N - 1)), int'($urandom_range(7)), 0);
            repeat ($urandom_range(3)) tick();
        end
        drain(3000);
        rdy_mode = 1;
        repeat (3) tick();
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== exp_q[k]) begin failures++; $display("FAIL rand_beat%0d: got %0h expected %0h", k, obs_q[k], exp_q[k]); end
        end
        checks++; if (multi_rdy !== 0) begin failures++; $display("FAIL rand_onehot: got %0d multi-ready cycles expected 0", multi_rdy); end
        checks++; if (err_seen !== 0) begin failures++; $display("FAIL rand_err: got %0d expected 0", err_seen); end
        checks++; if (stall_viol !== 0) begin failures++; $display("FAIL rand_stable: got %0d expected 0", stall_viol); end
        checks++; if (fifo_level_o !== 4'd0) begin failures++; $display("FAIL rand_level: got %0d expected 0", fifo_level_o); end
        clear_sb();
    endtask

    task automatic test_reset_mid_burst();
        int n;
        valid_pct = 100; rdy_mode = 1; clear_sb();
        push_burst(6, 5, 0);
        n = 0;
        while (obs_q.size() < 2 && n < 30) begin tick(); n++; end
        checks++; if (obs_q.size() !== 2) begin failures++; $display("FAIL rstmid_progress: got %0d beats expected 2", obs_q.size()); end
        rst_n = 1'b0;
        #1;
        checks++; if (wvalid_o !== 1'b0 || wready_o !== '0) begin failures++; $display("FAIL rstmid_handshake: got v%0b r%b expected 0 0", wvalid_o, wready_o); end
        checks++; if ({wdata_o, wstrb_o, wuser_o, wlast_o} !== '0) begin failures++; $display("FAIL rstmid_payload: got %0h expected 0", {wdata_o, wstrb_o, wuser_o, wlast_o}); end
        checks++; if (fifo_level_o !== '0 || grant_id_o !== 1'b1) begin failures++; $display("FAIL rstmid_fifo: got level %0d grant %0b expected 0 1", fifo_level_o, grant_id_o); end
        checks++; if (err_port_o !== '0 || dbg_state_o !== 1'b0) begin failures++; $display("FAIL rstmid_state: got port %0d state %0b expected 0 0", err_port_o, dbg_state_o); end
        for (int i = 0; i < N; i++) port_q[i].delete();
        wvalid_i = '0;
        clear_sb();
        stalled_prev = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (fifo_level_o !== '0 || wvalid_o !== 1'b0) begin failures++; $display("FAIL rstmid_after: got level %0d valid %0b expected 0 0", fifo_level_o, wvalid_o); end
        push_burst(6, 1, 0);
        drain(100);
        checks++; if (obs_q.size() !== 2) begin failures++; $display("FAIL rstmid_resume_count: got %0d expected 2", obs_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== exp_q[k]) begin failures++; $display("FAIL rstmid_resume_beat%0d: got %0h expected %0h", k, obs_q[k], exp_q[k]); end
        end
        clear_sb();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_beat();
        test_ordered_bursts();
        test_full_fifo();
        test_wlast_mismatch();
        test_backpressure();
        test_random();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
